// File: rtl/wb_defs.sv
// Shared write-back definitions: register/data widths and the queued-entry layout.
// Entry layout, MSB first: {valid, a3, wd, pc}.
package wb_defs;
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;
    localparam int ENTRY_W   = 1 + REG_W + 2 * DATA_W;
    localparam int PC_LSB    = 0;
    localparam int WD_LSB    = DATA_W;
    localparam int A3_LSB    = 2 * DATA_W;
    localparam int VALID_BIT = A3_LSB + REG_W;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    function automatic logic entry_hit(input wb_entry_t e, input logic [REG_W-1:0] addr);
        return e.valid && (e.a3 == addr);
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// MDU result queue with per-entry WAW kill and two pending-address lookups.
// Latency: push visible at head on the next cycle; backpressure is the caller's job (count_o).
module wb_fifo
    import wb_defs::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  wb_entry_t        push_dat_i,
    input  logic             pop_i,
    input  logic             kill_i,
    input  logic [REG_W-1:0] kill_a3_i,
    input  logic [REG_W-1:0] q1_addr_i,
    input  logic [REG_W-1:0] q2_addr_i,
    output wb_entry_t        head_o,
    output logic [PTR_W:0]   count_o,
    output logic             q1_pending_o,
    output logic             q2_pending_o
);
    wb_entry_t        entry_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] occupied;
    wb_entry_t        push_ent;
    logic             q1_hit, q2_hit;

    // A slot is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_occ
        logic [PTR_W-1:0] off;
        assign off         = PTR_W'(g) - head_q;
        assign occupied[g] = {1'b0, off} < count_q;
    end

    always_comb begin
        push_ent = push_dat_i;
        if (kill_i && (push_dat_i.a3 == kill_a3_i)) begin
            push_ent.valid = 1'b0;
        end
    end

    always_comb begin
        q1_hit = 1'b0;
        q2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && entry_hit(entry_q[i], q1_addr_i)) q1_hit = 1'b1;
            if (occupied[i] && entry_hit(entry_q[i], q2_addr_i)) q2_hit = 1'b1;
        end
    end

    always_comb begin
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else begin
            if (kill_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entry_q[i].a3 == kill_a3_i) entry_q[i].valid <= 1'b0;
                end
            end
            if (push_i) begin
                entry_q[tail_q] <= push_ent;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_o       = entry_q[head_q];
    assign count_o      = count_q;
    assign q1_pending_o = (q1_addr_i != '0) && q1_hit;
    assign q2_pending_o = (q2_addr_i != '0) && q2_hit;
endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-back arbiter: pipeline W stage has priority, MDU results queue and drain in idle slots.
// Latency 1 cycle (pipeline), 2 cycles (MDU via queue); m_ready drops at full. Optional WB_TRACE_EN prints commits.
module grf_wb_arbiter
    import wb_defs::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_we,
    input  logic [REG_W-1:0]  p_a3,
    input  logic [DATA_W-1:0] p_wd,
    input  logic [DATA_W-1:0] p_pc,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [REG_W-1:0]  m_a3,
    input  logic [DATA_W-1:0] m_wd,
    input  logic [DATA_W-1:0] m_pc,
    input  logic [REG_W-1:0]  q1_addr,
    input  logic [REG_W-1:0]  q2_addr,
    output logic              q1_pending,
    output logic              q2_pending,
    output logic              WE,
    output logic [REG_W-1:0]  A3,
    output logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] PC,
    output logic [PTR_W:0]    count
);
    logic              pw, push, pop;
    wb_entry_t         m_ent, head;
    logic              we_q, we_d;
    logic [REG_W-1:0]  a3_q, a3_d;
    logic [DATA_W-1:0] wd_q, wd_d, pc_q, pc_d;

    // Writes to $0 are dropped at the source so they never win arbitration or kill entries.
    assign pw      = p_we && (p_a3 != '0);
    assign m_ready = count < (PTR_W + 1)'(DEPTH);
    assign push    = m_valid && m_ready;
    assign pop     = !pw && (count != '0);
    assign m_ent   = '{valid: (m_a3 != '0), a3: m_a3, wd: m_wd, pc: m_pc};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_dat_i   (m_ent),
        .pop_i        (pop),
        .kill_i       (pw),
        .kill_a3_i    (p_a3),
        .q1_addr_i    (q1_addr),
        .q2_addr_i    (q2_addr),
        .head_o       (head),
        .count_o      (count),
        .q1_pending_o (q1_pending),
        .q2_pending_o (q2_pending)
    );

    always_comb begin
        we_d = 1'b0;
        a3_d = a3_q;
        wd_d = wd_q;
        pc_d = pc_q;
        if (pw) begin
            we_d = 1'b1;
            a3_d = p_a3;
            wd_d = p_wd;
            pc_d = p_pc;
        end else if (pop) begin
            we_d = head.valid;
            a3_d = head.a3;
            wd_d = head.wd;
            pc_d = head.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q <= 1'b0;
            a3_q <= '0;
            wd_q <= '0;
            pc_q <= '0;
        end else begin
            we_q <= we_d;
            a3_q <= a3_d;
            wd_q <= wd_d;
            pc_q <= pc_d;
        end
    end

    assign WE = we_q;
    assign A3 = a3_q;
    assign WD = wd_q;
    assign PC = pc_q;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (we_q && !reset) $display("%d@%h: $%d <= %h", $time, pc_q, a3_q, wd_q);
    end
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed table-driven bench for grf_wb_arbiter plus a hand-written full-queue sequence.
module tb_grf_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_we = 1'b0;
    logic [4:0]  p_a3 = '0;
    logic [31:0] p_wd = '0, p_pc = '0;
    logic        m_valid = 1'b0;
    logic        m_ready;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd = '0, m_pc = '0;
    logic [4:0]  q1_addr = '0, q2_addr = '0;
    logic        q1_pending, q2_pending;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD, PC;
    logic [2:0]  count;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
        .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_pending(q1_pending), .q2_pending(q2_pending),
        .WE(WE), .A3(A3), .WD(WD), .PC(PC), .count(count)
    );

    typedef struct {
        logic        rst, pwe;
        logic [4:0]  pa3;
        logic [31:0] pwd, ppc;
        logic        mv;
        logic [4:0]  ma3;
        logic [31:0] mwd, mpc;
        logic [4:0]  q1, q2;
        logic        chk, ewe;
        logic [4:0]  ea3;
        logic [31:0] ewd, epc;
        logic [2:0]  ecnt;
        logic        erdy, eq1, eq2;
    } vec_t;

    vec_t vecs[$];

    // Inputs for this cycle, then the outputs expected during the same cycle (before its edge).
    task automatic add(input int rst, pwe, pa3, pwd, ppc, mv, ma3, mwd, mpc, q1, q2,
                       input int chk, ewe, ea3, ewd, epc, ecnt, erdy, eq1, eq2);
        vec_t v;
        v.rst = 1'(rst);  v.pwe = 1'(pwe); v.pa3 = 5'(pa3); v.pwd = 32'(pwd); v.ppc = 32'(ppc);
        v.mv  = 1'(mv);   v.ma3 = 5'(ma3); v.mwd = 32'(mwd); v.mpc = 32'(mpc);
        v.q1  = 5'(q1);   v.q2  = 5'(q2);
        v.chk = 1'(chk);  v.ewe = 1'(ewe); v.ea3 = 5'(ea3); v.ewd = 32'(ewd); v.epc = 32'(epc);
        v.ecnt = 3'(ecnt); v.erdy = 1'(erdy); v.eq1 = 1'(eq1); v.eq2 = 1'(eq2);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, pwe, input logic [4:0] pa3, input logic [31:0] pwd, ppc,
                         input logic mv, input logic [4:0] ma3, input logic [31:0] mwd, mpc);
        reset = rst; p_we = pwe; p_a3 = pa3; p_wd = pwd; p_pc = ppc;
        m_valid = mv; m_a3 = ma3; m_wd = mwd; m_pc = mpc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] seen[$];
        logic [4:0] exp_seq[3];
        //   rst pwe pa3 pwd    ppc     mv ma3 mwd    mpc     q1 q2  chk we a3 wd     pc      cnt rdy q1p q2p
        add(1, 0, 0,  0,     0,      0, 0,  0,     0,      0, 0,  0, 0, 0, 0,     0,      0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      5, 0,  1, 0, 0, 0,     0,      0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      1, 5,  'hA,   'h3000, 5, 0,  1, 0, 0, 0,     0,      0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      5, 0,  1, 0, 0, 0,     0,      1, 1, 1, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      5, 0,  1, 1, 5, 'hA,   'h3000, 0, 1, 0, 0);
        add(0, 1, 3,  'h33,  'h1000, 1, 6,  'h66,  'h3006, 6, 9,  1, 0, 5, 'hA,   'h3000, 0, 1, 0, 0);
        add(0, 1, 3,  'h33,  'h1000, 1, 7,  'h77,  'h3007, 6, 9,  1, 1, 3, 'h33,  'h1000, 1, 1, 1, 0);
        add(0, 1, 3,  'h33,  'h1000, 1, 8,  'h88,  'h3008, 6, 9,  1, 1, 3, 'h33,  'h1000, 2, 1, 1, 0);
        add(0, 1, 3,  'h33,  'h1000, 1, 9,  'h99,  'h3009, 6, 9,  1, 1, 3, 'h33,  'h1000, 3, 1, 1, 0);
        add(0, 1, 3,  'h33,  'h1000, 1, 10, 'hAA,  'h300A, 6, 9,  1, 1, 3, 'h33,  'h1000, 4, 0, 1, 1);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      6, 9,  1, 1, 3, 'h33,  'h1000, 4, 0, 1, 1);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      6, 9,  1, 1, 6, 'h66,  'h3006, 3, 1, 0, 1);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      6, 9,  1, 1, 7, 'h77,  'h3007, 2, 1, 0, 1);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      6, 9,  1, 1, 8, 'h88,  'h3008, 1, 1, 0, 1);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      6, 9,  1, 1, 9, 'h99,  'h3009, 0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      1, 4,  1,     'h3100, 4, 0,  1, 0, 9, 'h99,  'h3009, 0, 1, 0, 0);
        add(0, 1, 4,  2,     'h1100, 0, 0,  0,     0,      4, 0,  1, 0, 9, 'h99,  'h3009, 1, 1, 1, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      4, 0,  1, 1, 4, 2,     'h1100, 1, 1, 0, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      4, 0,  1, 0, 4, 1,     'h3100, 0, 1, 0, 0);
        add(0, 1, 12, 'hC1,  'h1200, 1, 12, 'hC2,  'h3200, 12, 0, 1, 0, 4, 1,     'h3100, 0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      12, 0, 1, 1, 12, 'hC1, 'h1200, 1, 1, 0, 0);
        add(0, 1, 0,  'hDEAD,'h1300, 0, 0,  0,     0,      0, 0,  1, 0, 12, 'hC2, 'h3200, 0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      1, 0,  'hE0,  'h3300, 0, 0,  1, 0, 12, 'hC2, 'h3200, 0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      0, 0,  1, 0, 12, 'hC2, 'h3200, 1, 1, 0, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      0, 0,  1, 0, 0, 'hE0,  'h3300, 0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      1, 20, 'h14,  'h3400, 20, 21, 1, 0, 0, 'hE0, 'h3300, 0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      1, 21, 'h15,  'h3500, 20, 21, 1, 0, 0, 'hE0, 'h3300, 1, 1, 1, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      20, 21, 1, 1, 20, 'h14, 'h3400, 1, 1, 0, 1);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      20, 21, 1, 1, 21, 'h15, 'h3500, 0, 1, 0, 0);
        add(0, 1, 1,  'h11,  'h1400, 1, 22, 'h16,  'h3600, 22, 24, 1, 0, 21, 'h15, 'h3500, 0, 1, 0, 0);
        add(0, 1, 1,  'h11,  'h1400, 1, 23, 'h17,  'h3700, 22, 24, 1, 1, 1, 'h11,  'h1400, 1, 1, 1, 0);
        add(0, 1, 1,  'h11,  'h1400, 1, 24, 'h18,  'h3800, 22, 24, 1, 1, 1, 'h11,  'h1400, 2, 1, 1, 0);
        add(1, 0, 0,  0,     0,      0, 0,  0,     0,      22, 24, 1, 1, 1, 'h11,  'h1400, 3, 1, 1, 1);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      22, 24, 1, 0, 0, 0,     0,      0, 1, 0, 0);
        add(0, 0, 0,  0,     0,      0, 0,  0,     0,      22, 24, 1, 0, 0, 0,     0,      0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].pwe, vecs[i].pa3, vecs[i].pwd, vecs[i].ppc,
                  vecs[i].mv, vecs[i].ma3, vecs[i].mwd, vecs[i].mpc);
            q1_addr = vecs[i].q1;
            q2_addr = vecs[i].q2;
            #1;
            if (vecs[i].chk) begin
                check("WE",         i, 32'(WE),         32'(vecs[i].ewe));
                check("A3",         i, 32'(A3),         32'(vecs[i].ea3));
                check("WD",         i, WD,              vecs[i].ewd);
                check("PC",         i, PC,              vecs[i].epc);
                check("count",      i, 32'(count),      32'(vecs[i].ecnt));
                check("m_ready",    i, 32'(m_ready),    32'(vecs[i].erdy));
                check("q1_pending", i, 32'(q1_pending), 32'(vecs[i].eq1));
                check("q2_pending", i, 32'(q2_pending), 32'(vecs[i].eq2));
            end
        end

        // Fill the queue behind a pipeline write, then offer a push while full and popping.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 5'd2, 32'h22, 32'h1500, 1'b1, 5'(25 + k), 32'(32'h100 + k), 32'(32'h3900 + k));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd29, 32'h105, 32'h3905);
        #1;
        check("full_count",    100, 32'(count),   32'd4);
        check("full_no_ready", 100, 32'(m_ready), 32'd0);
        @(negedge clk);
        #1;
        check("after_pop_count", 101, 32'(count),   32'd3);
        check("after_pop_ready", 101, 32'(m_ready), 32'd1);
        check("after_pop_A3",    101, 32'(A3),      32'd25);
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        check("push_pop_count", 102, 32'(count), 32'd3);
        check("push_pop_A3",    102, 32'(A3),    32'd26);

        exp_seq[0] = 5'd27;
        exp_seq[1] = 5'd28;
        exp_seq[2] = 5'd29;
        for (int c = 0; c < 10 && seen.size() < 3; c++) begin
            @(posedge clk);
            #1;
            if (WE) seen.push_back(A3);
        end
        check("drain_writes", 103, 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            check("drain_order", 104 + k, 32'(seen[k]), 32'(exp_seq[k]));
        end
        check("drain_empty", 107, 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
